// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - Iterative RV32M multiply/divide sequencer with fixed 33-cycle latency
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0]   ONE      = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_W    = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
    localparam logic [5:0]        LAST_IT  = 6'(XLEN-1);

    state_t state, state_nx;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   rem;
    logic [2*XLEN-1:0] acc;
    logic [5:0]        cnt;
    logic              neg_a;
    logic              neg_res;
    logic              div_zero;
    logic              div_ovf;

    logic              accept;
    logic              sgn1, sgn2;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     trial;
    logic [XLEN:0]     diff;
    logic              qbit;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_val;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready && !flush;

    // Operand decode: signedness by funct3, magnitudes feed the unsigned core.
    always_comb begin
        sgn1  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        sgn2  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg = sgn1 && rs1[XLEN-1];
        b_neg = sgn2 && rs2[XLEN-1];
        a_mag = a_neg ? (~rs1 + ONE) : rs1;
        b_mag = b_neg ? (~rs2 + ONE) : rs2;
    end

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
        trial   = {rem, acc[XLEN-1]};
        diff    = trial - {1'b0, opnd};
        qbit    = !diff[XLEN];
    end

    // Sign fix-up and output selection; special divide cases override here only.
    always_comb begin
        prod_fix = neg_res ? (~acc + ONE_W) : acc;
        quo_fix  = neg_res ? (~acc[XLEN-1:0] + ONE) : acc[XLEN-1:0];
        rem_fix  = neg_a ? (~rem + ONE) : rem;
        fix_val  = {XLEN{1'b0}};
        case (op_q)
            3'b000: fix_val = prod_fix[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100,
            3'b101: begin
                if (div_zero)     fix_val = ALL_ONES;
                else if (div_ovf) fix_val = INT_MIN;
                else              fix_val = quo_fix;
            end
            default: begin
                // With a zero divisor the remainder holds |rs1| and rem_fix restores rs1.
                if (div_ovf && !div_zero) fix_val = {XLEN{1'b0}};
                else                      fix_val = rem_fix;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) state_nx = S_CALC;
                S_CALC: if (cnt == LAST_IT) state_nx = S_FIX;
                S_FIX:  state_nx = S_DONE;
                S_DONE: if (out_ready) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 3'b000;
            opnd     <= {XLEN{1'b0}};
            rem      <= {XLEN{1'b0}};
            acc      <= {(2*XLEN){1'b0}};
            cnt      <= 6'd0;
            neg_a    <= 1'b0;
            neg_res  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            result   <= {XLEN{1'b0}};
        end else begin
            if (accept) begin
                op_q     <= op;
                neg_a    <= a_neg;
                neg_res  <= a_neg ^ b_neg;
                div_zero <= (rs2 == {XLEN{1'b0}});
                div_ovf  <= op[2] && sgn2 && (rs1 == INT_MIN) && (rs2 == ALL_ONES);
                cnt      <= 6'd0;
                rem      <= {XLEN{1'b0}};
                if (op[2]) begin
                    opnd <= b_mag;
                    acc  <= {{XLEN{1'b0}}, a_mag};
                end else begin
                    opnd <= a_mag;
                    acc  <= {{XLEN{1'b0}}, b_mag};
                end
            end else if (state == S_CALC) begin
                cnt <= cnt + 6'd1;
                if (op_q[2]) begin
                    rem              <= qbit ? diff[XLEN-1:0] : trial[XLEN-1:0];
                    acc[XLEN-1:0]    <= {acc[XLEN-2:0], qbit};
                end else begin
                    acc <= {mul_sum, acc[XLEN-1:1]};
                end
            end
            if (state == S_FIX && !flush) result <= fix_val;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - Directed and randomized bench for muldiv_seq against an arithmetic model
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        int sa, sb;
        xa = (o inside {3'd1, 3'd2}) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (o == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        sa = a;
        sb = b;
        case (o)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        @(negedge clk);
        op = o;
        rs1 = a;
        rs2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
        op = 3'($urandom_range(0, 7));
    endtask

    // Runs one op, checks latency/result, holds out_ready low for hold cycles, then hands off.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        int n;
        logic [31:0] exp;
        exp = model(o, a, b);
        start_op(o, a, b);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n <= 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_res"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op = 3'd0;
            rs1 = 32'd5;
            rs2 = 32'd5;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_res"}, result, exp);
            chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_handoff_vld"}, 32'(out_valid), 32'd0);
        chk({tag, "_handoff_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_handoff_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] prev;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 0, "mul");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhu");
        run_op(3'd1, 32'h80000000, 32'h80000000, 0, "mulh");
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 0, "mulhsu");
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 0, "div_neg");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 0, "rem_neg");
        run_op(3'd5, 32'd100, 32'd7, 0, "divu");
        run_op(3'd7, 32'd100, 32'd7, 0, "remu");
        run_op(3'd4, 32'h12345678, 32'd0, 0, "div_zero");
        run_op(3'd7, 32'h00001234, 32'd0, 0, "remu_zero");
        run_op(3'd6, 32'hFFFFFF00, 32'd0, 0, "rem_zero_neg");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0, "rem_ovf");
        run_op(3'd5, 32'd100, 32'd7, 5, "backpressure");

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 0, $sformatf("rand%0d_op%0d", i, ro));
        end

        prev = result;
        start_op(3'd4, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_result_kept", result, prev);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("flush_no_out_valid", seen, 0);

        @(negedge clk);
        op = 3'd0;
        rs1 = 32'd2;
        rs2 = 32'd2;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_vs_valid_busy", 32'(busy), 32'd0);
        chk("flush_vs_valid_rdy", 32'(in_ready), 32'd1);

        run_op(3'd0, 32'd9, 32'd9, 0, "after_flush");

        start_op(3'd1, 32'hDEADBEEF, 32'h12345678);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_result", result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 32'd3, 32'd4, 0, "post_rst_mul");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
